// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, data-phase FSM states and byte-lane helpers
// for the SRAM responder.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_LAST = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_e;

   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         HSIZE_BYTE: m = 4'b0001 << off;
         HSIZE_HALF: m = 4'b0011 << off;
         HSIZE_WORD: m = 4'b1111;
         default:    m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic size_legal(input logic [2:0] size, input logic [1:0] off);
      logic ok;
      case (size)
         HSIZE_BYTE: ok = 1'b1;
         HSIZE_HALF: ok = ~off[0];
         HSIZE_WORD: ok = (off == 2'b00);
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Expands a 4-bit lane mask into a 32-bit bit mask.
   function automatic logic [31:0] lane_bits(input logic [3:0] m);
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 4; i++) b[8*i +: 8] = {8{m[i]}};
      return b;
   endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-port signal bundle between the matrix (master modport)
// and one SRAM responder (slave modport).
interface ahb_sram_slave_if;

   // A transfer is taken when S_HSEL, S_HREADY and S_HTRANS[1] are all high
   // on a rising edge; its data phase ends on the first edge where
   // S_HREADYOUT is high, and the matrix mirrors that back on S_HREADY.
   logic        S_HSEL;
   logic [1:0]  S_HTRANS;
   logic        S_HWRITE;
   logic        S_HMASTLOCK;
   logic [2:0]  S_HSIZE;
   logic [2:0]  S_HBURST;
   logic [3:0]  S_HPROT;
   logic [31:0] S_HADDR;
   logic [31:0] S_HWDATA;
   logic        S_HREADY;
   logic        S_HREADYOUT;
   logic [31:0] S_HRDATA;
   logic        S_HRESP;

   modport slave (
      input  S_HSEL, S_HTRANS, S_HWRITE, S_HMASTLOCK, S_HSIZE, S_HBURST,
             S_HPROT, S_HADDR, S_HWDATA, S_HREADY,
      output S_HREADYOUT, S_HRDATA, S_HRESP
   );

   modport master (
      output S_HSEL, S_HTRANS, S_HWRITE, S_HMASTLOCK, S_HSIZE, S_HBURST,
             S_HPROT, S_HADDR, S_HWDATA, S_HREADY,
      input  S_HREADYOUT, S_HRDATA, S_HRESP
   );

endinterface

// File: rtl/ahb_sram_array.sv
// Byte-writable synchronous-read SRAM with independent read and write
// addresses; a same-edge read of the written word returns the old data.
module ahb_sram_array #(
   parameter int ADDR_BITS = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [31:0]          rd_data,
   input  logic [3:0]           wr_be,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [31:0]          wr_data
);

   logic [31:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   // Only the output register is reset; the array contents survive reset.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder fronting a byte-writable SRAM: address-phase capture,
// wait-state FSM, two-cycle ERROR response and write-to-read forwarding.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic            HCLK,
   input  logic            HRESET,
   ahb_sram_slave_if.slave bus,
   output state_e          dbg_state
);

   localparam logic [1:0] WAIT_LOAD = 2'(WAIT_STATES);
   localparam bit         HAS_WAIT  = (WAIT_STATES > 0);

   state_e                state_q, state_d;
   logic [1:0]            wait_cnt_q;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [3:0]            lanes_q;
   logic                  write_q;
   logic                  legal_q;

   logic                  accept;
   logic [1:0]            byte_off;
   logic [ADDR_BITS-1:0]  word_addr;
   logic                  legal;
   logic                  hreadyout;
   logic                  hresp;

   logic                  rd_en;
   logic [31:0]           ram_rdata;
   logic [3:0]            wr_be;
   logic                  fwd_hit;
   logic [3:0]            fwd_mask_q;
   logic [31:0]           fwd_data_q;

   assign accept    = bus.S_HSEL & bus.S_HREADY & bus.S_HTRANS[1];
   assign byte_off  = bus.S_HADDR[1:0];
   assign word_addr = bus.S_HADDR[ADDR_BITS+1:2];
   assign legal     = size_legal(bus.S_HSIZE, byte_off);

   // Address-phase capture for the data phase that follows.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         addr_q  <= '0;
         lanes_q <= '0;
         write_q <= 1'b0;
         legal_q <= 1'b0;
      end else if (accept) begin
         addr_q  <= word_addr;
         lanes_q <= lane_mask(bus.S_HSIZE, byte_off);
         write_q <= bus.S_HWRITE;
         legal_q <= legal;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET)                    wait_cnt_q <= 2'd0;
      else if (state_q == ST_WAIT)   wait_cnt_q <= wait_cnt_q - 2'd1;
      else if (accept && legal)      wait_cnt_q <= WAIT_LOAD;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // IDLE, LAST and ERR2 are the cycles where a new address phase may land.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_LAST, ST_ERR2: begin
            if (!accept)       state_d = ST_IDLE;
            else if (!legal)   state_d = ST_ERR1;
            else if (HAS_WAIT) state_d = ST_WAIT;
            else               state_d = ST_LAST;
         end
         ST_WAIT: if (wait_cnt_q == 2'd1) state_d = ST_LAST;
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      case (state_q)
         ST_WAIT: hreadyout = 1'b0;
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
         end
         ST_ERR2: hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   assign bus.S_HREADYOUT = hreadyout;
   assign bus.S_HRESP     = hresp;
   assign dbg_state       = state_q;

   // The write lands on the edge closing LAST; a reset on that edge drops it.
   assign wr_be = (state_q == ST_LAST && write_q && legal_q && !HRESET) ? lanes_q : 4'b0000;

   assign rd_en   = accept & ~bus.S_HWRITE & ~HRESET;
   assign fwd_hit = rd_en & (addr_q == word_addr);

   // The array returns pre-write data on a same-edge read, so the pending
   // write lanes are captured here and overlaid on its output.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         fwd_mask_q <= 4'b0000;
         fwd_data_q <= '0;
      end else if (rd_en) begin
         fwd_mask_q <= fwd_hit ? wr_be : 4'b0000;
         fwd_data_q <= bus.S_HWDATA;
      end
   end

   assign bus.S_HRDATA = (fwd_data_q & lane_bits(fwd_mask_q)) |
                         (ram_rdata & ~lane_bits(fwd_mask_q));

   ahb_sram_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk     (HCLK),
      .rst     (HRESET),
      .rd_en   (rd_en),
      .rd_addr (word_addr),
      .rd_data (ram_rdata),
      .wr_be   (wr_be),
      .wr_addr (addr_q),
      .wr_data (bus.S_HWDATA)
   );

   logic unused_bits;
   assign unused_bits = ^{bus.S_HMASTLOCK, bus.S_HBURST, bus.S_HPROT,
                          bus.S_HADDR[31:ADDR_BITS+2], bus.S_HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with no wait states and
// one with two, sharing a single master-side stimulus driver.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- master-side stimulus ----------------
  logic        hsel         = 1'b0;
  logic [1:0]  htrans       = HTRANS_IDLE;
  logic        hwrite       = 1'b0;
  logic [2:0]  hsize        = HSIZE_WORD;
  logic [31:0] haddr        = 32'h0;
  logic [31:0] hwdata       = 32'h0;
  logic        use_ws2      = 1'b0;
  logic        hready_block = 1'b0;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  state_e dbg0, dbg2;

  ahb_sram_slave_if bus0();
  ahb_sram_slave_if bus2();

  assign bus0.S_HSEL      = hsel & ~use_ws2;
  assign bus2.S_HSEL      = hsel & use_ws2;
  assign bus0.S_HTRANS    = htrans;
  assign bus2.S_HTRANS    = htrans;
  assign bus0.S_HWRITE    = hwrite;
  assign bus2.S_HWRITE    = hwrite;
  assign bus0.S_HMASTLOCK = 1'b0;
  assign bus2.S_HMASTLOCK = 1'b0;
  assign bus0.S_HSIZE     = hsize;
  assign bus2.S_HSIZE     = hsize;
  assign bus0.S_HBURST    = 3'd1;
  assign bus2.S_HBURST    = 3'd1;
  assign bus0.S_HPROT     = 4'b0011;
  assign bus2.S_HPROT     = 4'b0011;
  assign bus0.S_HADDR     = haddr;
  assign bus2.S_HADDR     = haddr;
  assign bus0.S_HWDATA    = hwdata;
  assign bus2.S_HWDATA    = hwdata;
  assign bus0.S_HREADY    = bus0.S_HREADYOUT & ~hready_block;
  assign bus2.S_HREADY    = bus2.S_HREADYOUT & ~hready_block;

  logic        rdy, rsp;
  logic [31:0] rdat;
  state_e      dbg;
  assign rdy  = use_ws2 ? bus2.S_HREADYOUT : bus0.S_HREADYOUT;
  assign rsp  = use_ws2 ? bus2.S_HRESP     : bus0.S_HRESP;
  assign rdat = use_ws2 ? bus2.S_HRDATA    : bus0.S_HRDATA;
  assign dbg  = use_ws2 ? dbg2             : dbg0;

  ahb_sram_slave #(.ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .bus(bus0), .dbg_state(dbg0)
  );

  ahb_sram_slave #(.ADDR_BITS(12), .WAIT_STATES(2)) dut2 (
    .HCLK(clk), .HRESET(rst), .bus(bus2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hxxxx_xxxx;
    return exp_q.pop_front();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_addr(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                            input logic [31:0] addr);
    hsel   = 1'b1;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  // One isolated NONSEQ transfer; hist collects {ready,resp} per data-phase cycle.
  task automatic xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output int nphase,
                      output logic [7:0] hist);
    @(posedge clk); #1 drive_addr(HTRANS_NONSEQ, wr, size, addr);
    @(posedge clk); #1 drive_idle(); hwdata = wdata;
    nphase = 0;
    hist   = 8'h00;
    rd     = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nphase++;
      hist = {hist[5:0], rdy, rsp};
      if (rdy) begin
        rd = rdat;
        break;
      end
    end
  endtask

  task automatic do_write(input string tag, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_phases);
    logic [31:0] rd;
    int          n;
    logic [7:0]  h;
    xfer(1'b1, size, addr, wdata, rd, n, h);
    check({tag, "_phases"}, 32'(n), 32'(exp_phases));
    check({tag, "_hist"}, 32'(h), 32'h02);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input int exp_phases);
    logic [31:0] rd;
    int          n;
    logic [7:0]  h;
    xfer(1'b0, HSIZE_WORD, addr, 32'h0, rd, n, h);
    check({tag, "_phases"}, 32'(n), 32'(exp_phases));
    check({tag, "_hist"}, 32'(h), 32'h02);
    check({tag, "_rdata"}, rd, pop_exp());
  endtask

  // Illegal transfer: expect (ready,resp) = (0,1) then (1,1).
  task automatic do_err(input string tag, input logic [2:0] size, input logic [31:0] addr);
    logic [31:0] rd;
    int          n;
    logic [7:0]  h;
    xfer(1'b1, size, addr, 32'hFFFF_FFFF, rd, n, h);
    check({tag, "_phases"}, 32'(n), 32'd2);
    check({tag, "_hist"}, 32'(h), 32'h07);
  endtask

  // Write immediately followed by a word read whose address phase overlaps LAST.
  task automatic wr_rd_b2b(input string tag, input logic [2:0] wsize, input logic [31:0] waddr,
                           input logic [31:0] wdata, input logic [31:0] raddr);
    @(posedge clk); #1 drive_addr(HTRANS_NONSEQ, 1'b1, wsize, waddr);
    @(posedge clk); #1 hwdata = wdata; drive_addr(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, raddr);
    @(negedge clk);
    check({tag, "_wr_ready"}, 32'(rdy), 32'd1);
    @(posedge clk); #1 drive_idle();
    @(negedge clk);
    check({tag, "_rd_ready"}, 32'(rdy), 32'd1);
    check({tag, "_rdata"}, rdat, pop_exp());
  endtask

  // Two-beat NONSEQ/SEQ read; each beat's data-phase length is counted.
  task automatic burst_rd2(input string tag, input logic [31:0] a0, input int exp_phases);
    int n;
    @(posedge clk); #1 drive_addr(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, a0);
    @(posedge clk); #1 drive_addr(HTRANS_SEQ, 1'b0, HSIZE_WORD, a0 + 32'd4);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n++;
      if (rdy) break;
    end
    check({tag, "_beat0_phases"}, 32'(n), 32'(exp_phases));
    check({tag, "_beat0_rdata"}, rdat, pop_exp());
    @(posedge clk); #1 drive_idle();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n++;
      if (rdy) break;
    end
    check({tag, "_beat1_phases"}, 32'(n), 32'(exp_phases));
    check({tag, "_beat1_rdata"}, rdat, pop_exp());
  endtask

  // Cycles that must not start a data phase on the zero-wait instance.
  task automatic no_accept(input string tag, input logic sel, input logic [1:0] trans,
                           input logic block);
    @(posedge clk); #1
    hsel = sel; htrans = trans; hwrite = 1'b1; hsize = HSIZE_WORD;
    haddr = 32'h10; hwdata = 32'h0; hready_block = block;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check({tag, "_ready"}, 32'(rdy), 32'd1);
      check({tag, "_resp"}, 32'(rsp), 32'd0);
      check({tag, "_state"}, 32'(dbg0), 32'(ST_IDLE));
    end
    @(posedge clk); #1 drive_idle(); hready_block = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 32'(bus0.S_HREADYOUT), 32'd1);
    check("rst_resp0", 32'(bus0.S_HRESP), 32'd0);
    check("rst_rdata0", bus0.S_HRDATA, 32'h0);
    check("rst_state0", 32'(dbg0), 32'(ST_IDLE));
    check("rst_ready2", 32'(bus2.S_HREADYOUT), 32'd1);
    check("rst_state2", 32'(dbg2), 32'(ST_IDLE));
    rst = 1'b0;

    // Zero wait states: word, byte and half accesses.
    do_write("wr_deadbeef", HSIZE_WORD, 32'h10, 32'hDEAD_BEEF, 1);
    exp_q.push_back(32'hDEAD_BEEF);
    do_read("rd_deadbeef", 32'h10, 1);
    do_write("wr_w0", HSIZE_WORD, 32'h00, 32'h0BAD_F00D, 1);
    do_write("wr_clr10", HSIZE_WORD, 32'h10, 32'h0000_0000, 1);
    do_write("wr_byte11", HSIZE_BYTE, 32'h11, 32'h1111_AA11, 1);
    do_write("wr_half12", HSIZE_HALF, 32'h12, 32'h5566_2222, 1);
    exp_q.push_back(32'h5566_AA00);
    do_read("rd_merge10", 32'h10, 1);

    // Write-to-read forwarding.
    exp_q.push_back(32'h1234_5678);
    wr_rd_b2b("fwd_word", HSIZE_WORD, 32'h20, 32'h1234_5678, 32'h20);
    exp_q.push_back(32'h9A34_5678);
    wr_rd_b2b("fwd_byte", HSIZE_BYTE, 32'h23, 32'h9AFF_FFFF, 32'h20);
    exp_q.push_back(32'h9A34_5678);
    wr_rd_b2b("nofwd_other", HSIZE_WORD, 32'h24, 32'h7777_7777, 32'h20);
    exp_q.push_back(32'h9A34_5678);
    do_read("rd_after_fwd", 32'h20, 1);
    exp_q.push_back(32'h7777_7777);
    do_read("rd_24", 32'h24, 1);

    // Illegal transfers leave memory untouched.
    do_err("err_word_02", HSIZE_WORD, 32'h02);
    do_err("err_size3", 3'd3, 32'h10);
    do_err("err_half_odd", HSIZE_HALF, 32'h11);
    exp_q.push_back(32'h0BAD_F00D);
    do_read("rd_w0_after_err", 32'h00, 1);
    exp_q.push_back(32'h5566_AA00);
    do_read("rd_10_after_err", 32'h10, 1);

    // Cycles without a valid accept.
    no_accept("idle_sel", 1'b1, HTRANS_IDLE, 1'b0);
    no_accept("busy_sel", 1'b1, HTRANS_BUSY, 1'b0);
    no_accept("nonseq_unsel", 1'b0, HTRANS_NONSEQ, 1'b0);
    no_accept("hready_low", 1'b1, HTRANS_NONSEQ, 1'b1);
    exp_q.push_back(32'h5566_AA00);
    do_read("rd_10_after_noacc", 32'h10, 1);

    // Two wait states.
    use_ws2 = 1'b1;
    do_write("ws2_wr40", HSIZE_WORD, 32'h40, 32'hCAFE_F00D, 3);
    do_write("ws2_wr44", HSIZE_WORD, 32'h44, 32'h1122_3344, 3);
    exp_q.push_back(32'hCAFE_F00D);
    do_read("ws2_rd40", 32'h40, 3);
    exp_q.push_back(32'hCAFE_F00D);
    exp_q.push_back(32'h1122_3344);
    burst_rd2("ws2_burst", 32'h40, 3);

    // Reset in the middle of a write's wait states.
    @(posedge clk); #1 drive_addr(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40);
    @(posedge clk); #1 drive_idle(); hwdata = 32'h5555_5555;
    @(negedge clk);
    check("rst_mid_wait_ready", 32'(rdy), 32'd0);
    check("rst_mid_wait_state", 32'(dbg), 32'(ST_WAIT));
    rst = 1'b1;
    @(negedge clk);
    check("rst_after_ready", 32'(rdy), 32'd1);
    check("rst_after_resp", 32'(rsp), 32'd0);
    check("rst_after_rdata", rdat, 32'h0);
    check("rst_after_state", 32'(dbg), 32'(ST_IDLE));
    rst = 1'b0;
    exp_q.push_back(32'hCAFE_F00D);
    do_read("ws2_rd40_after_rst", 32'h40, 3);

    // ---------------- final report ----------------
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
